// File: rtl/adc_window_stats_pkg.sv
// Shared types and constants for the ADC window statistics block.
package adc_disp_pkg;
  localparam int CODE_W           = 12;
  localparam int DISP_MAX_DEFAULT = 9999;

  typedef enum logic [1:0] {
    MODE_AVG = 2'd0,
    MODE_MIN = 2'd1,
    MODE_MAX = 2'd2,
    MODE_P2P = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CODE_W-1:0] avg;
    logic [CODE_W-1:0] mn;
    logic [CODE_W-1:0] mx;
    logic [CODE_W-1:0] p2p;
  } win_stats_t;
endpackage

// File: rtl/adc_window_stats_if.sv
// Sample input, control and display-facing outputs of adc_window_stats.
interface adc_window_stats_if;
  import adc_disp_pkg::*;

  logic [15:0]       s_in;
  mode_e             mode;
  logic              hold;
  logic              clear;
  logic [15:0]       disp_mv;
  logic              disp_valid;
  logic [CODE_W-1:0] win_code;

  modport master (output s_in, mode, hold, clear, input disp_mv, disp_valid, win_code);
  modport slave  (input s_in, mode, hold, clear, output disp_mv, disp_valid, win_code);
endinterface

// File: rtl/adc_window_stats_accum.sv
// Decimates the ADC sample and accumulates avg/min/max/p2p over 2^LOG2_N ticks.
module adc_win_accum
  import adc_disp_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int LOG2_N     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_in,
  input  logic        clear,
  output logic        done,
  output win_stats_t  stats
);
  localparam int TW    = $clog2(SAMPLE_DIV);
  localparam int ACC_W = CODE_W + LOG2_N;

  logic [TW-1:0]     tick_cnt;
  logic [LOG2_N-1:0] cnt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CODE_W-1:0] mn, mx, mn_nxt, mx_nxt, code;
  logic              tick;
  logic              unused_lsbs;

  assign code        = s_in[15:4];
  assign unused_lsbs = ^s_in[3:0];
  assign tick        = (tick_cnt == TW'(SAMPLE_DIV - 1));
  // Next-state values fold in the current code so the final tick lands in its own window.
  assign acc_nxt     = acc + ACC_W'(code);
  assign mn_nxt      = (code < mn) ? code : mn;
  assign mx_nxt      = (code > mx) ? code : mx;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (!rst_n || clear) begin
      tick_cnt <= '0;
      cnt      <= '0;
      acc      <= '0;
      mn       <= '1;
      mx       <= '0;
      if (!rst_n) stats <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (&cnt) begin
          done      <= 1'b1;
          stats.avg <= CODE_W'(acc_nxt >> LOG2_N);
          stats.mn  <= mn_nxt;
          stats.mx  <= mx_nxt;
          stats.p2p <= mx_nxt - mn_nxt;
          cnt       <= '0;
          acc       <= '0;
          mn        <= '1;
          mx        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          acc <= acc_nxt;
          mn  <= mn_nxt;
          mx  <= mx_nxt;
        end
      end
    end
  end
endmodule

// File: rtl/adc_window_stats.sv
// Window statistics top: mode select, mV scaling, saturation and hold/clear gating.
module adc_window_stats
  import adc_disp_pkg::*;
#(
  parameter int SAMPLE_DIV  = 100000,
  parameter int LOG2_N      = 8,
  parameter int SCALE_NUM   = 1000,
  parameter int SCALE_SHIFT = 12,
  parameter int DISP_MAX    = DISP_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_window_stats_if.slave bus
);
  localparam int PROD_W = CODE_W + $clog2(SCALE_NUM + 1);

  logic              done;
  win_stats_t        stats;
  logic [CODE_W-1:0] sel, s1_code;
  logic [PROD_W-1:0] prod, mv;
  logic              s1_vld, show;

  adc_win_accum #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .LOG2_N    (LOG2_N)
  ) u_accum (
    .clk  (clk),
    .rst_n(rst_n),
    .s_in (bus.s_in),
    .clear(bus.clear),
    .done (done),
    .stats(stats)
  );

  always_comb begin
    sel = stats.avg;
    case (bus.mode)
      MODE_AVG: sel = stats.avg;
      MODE_MIN: sel = stats.mn;
      MODE_MAX: sel = stats.mx;
      MODE_P2P: sel = stats.p2p;
    endcase
  end

  assign mv   = prod >> SCALE_SHIFT;
  // A held or cleared result is dropped outright; nothing is queued for later.
  assign show = s1_vld & ~bus.hold & ~bus.clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld         <= 1'b0;
      s1_code        <= '0;
      prod           <= '0;
      bus.disp_mv    <= '0;
      bus.win_code   <= '0;
      bus.disp_valid <= 1'b0;
    end else begin
      s1_vld <= done & ~bus.clear;
      if (done) begin
        s1_code <= sel;
        prod    <= PROD_W'(sel) * PROD_W'(SCALE_NUM);
      end
      bus.disp_valid <= show;
      if (show) begin
        bus.disp_mv  <= (64'(mv) > 64'(DISP_MAX)) ? 16'(DISP_MAX) : 16'(mv);
        bus.win_code <= s1_code;
      end
    end
  end
endmodule

// File: tb/tb_adc_window_stats.sv
// Scoreboard bench for adc_window_stats with SAMPLE_DIV=4, LOG2_N=2.
module tb_adc_window_stats;
  import adc_disp_pkg::*;

  typedef struct {
    int mv;
    int code;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_in = '0;
  logic [1:0]  mode = '0;
  logic        hold1 = 1'b0, hold2 = 1'b1, clear = 1'b0;
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  exp_t        q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_window_stats_if b1();
  adc_window_stats_if b2();

  assign b1.s_in  = s_in;
  assign b1.mode  = mode_e'(mode);
  assign b1.hold  = hold1;
  assign b1.clear = clear;
  assign b2.s_in  = s_in;
  assign b2.mode  = mode_e'(mode);
  assign b2.hold  = hold2;
  assign b2.clear = clear;

  adc_window_stats #(.SAMPLE_DIV(4), .LOG2_N(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  adc_window_stats #(.SAMPLE_DIV(4), .LOG2_N(2), .SCALE_NUM(40000)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b1.disp_valid) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL dut1_unexpected: disp_valid with disp_mv=%0d, expected no output (cycle %0d)", b1.disp_mv, cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1_disp_mv", int'(b1.disp_mv), e.mv);
        chk("dut1_win_code", int'(b1.win_code), e.code);
        chk("dut1_latency_cycle", cyc, e.due);
      end
    end
    if (b2.disp_valid) begin
      if (q2.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL dut2_unexpected: disp_valid with disp_mv=%0d, expected no output (cycle %0d)", b2.disp_mv, cyc);
      end else begin
        e = q2.pop_front();
        chk("dut2_disp_mv", int'(b2.disp_mv), e.mv);
        chk("dut2_win_code", int'(b2.win_code), e.code);
        chk("dut2_latency_cycle", cyc, e.due);
      end
    end
  end

  // One window of four tick periods; mode/hold change only after the previous
  // window's stage-1/stage-2 edges so each setting governs this window's result.
  task automatic run_window(input int c0, c1, c2, c3, input int m, input bit h1, h2,
                            input bit push, input int emv1, ecode, emv2);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      s_in = 16'(c[i] << 4);
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if (i == 0 && j == 0) mode = 2'(m);
        if (i == 0 && j == 1) begin hold1 = h1; hold2 = h2; end
      end
    end
    if (push) begin
      if (!h1) q1.push_back('{emv1, ecode, cyc + 2});
      if (!h2) q2.push_back('{emv2, ecode, cyc + 2});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_disp_mv", int'(b1.disp_mv), 0);
    chk("reset_win_code", int'(b1.win_code), 0);
    chk("reset_disp_valid", int'(b1.disp_valid), 0);
    rst_n = 1'b1;

    // full-scale constant
    run_window(4095, 4095, 4095, 4095, 0, 0, 1, 1, 999, 4095, 0);
    run_window(4095, 4095, 4095, 4095, 0, 0, 1, 1, 999, 4095, 0);
    // ramp under each mode
    run_window(100, 200, 300, 400, 0, 0, 1, 1, 61, 250, 0);
    run_window(100, 200, 300, 400, 1, 0, 1, 1, 24, 100, 0);
    run_window(100, 200, 300, 400, 2, 0, 1, 1, 97, 400, 0);
    run_window(100, 200, 300, 400, 3, 0, 1, 1, 73, 300, 0);
    // saturation on the large-scale instance
    run_window(4095, 4095, 4095, 4095, 0, 0, 0, 1, 999, 4095, 9999);
    // hold across two window ends, then release
    run_window(2000, 2000, 2000, 2000, 0, 1, 1, 1, 0, 0, 0);
    run_window(2000, 2000, 2000, 2000, 0, 1, 1, 1, 0, 0, 0);
    run_window(1000, 1000, 1000, 1000, 0, 0, 1, 1, 244, 1000, 0);
    chk("hold_kept_disp_mv", int'(b1.disp_mv), 999);
    chk("hold_kept_win_code", int'(b1.win_code), 4095);

    // clear after two ticks restarts the window
    s_in = 16'(4000 << 4);
    repeat (8) @(posedge clk);
    #1;
    clear = 1'b1;
    s_in  = '0;
    @(posedge clk); #1;
    clear = 1'b0;
    run_window(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    run_window(0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);

    // reset one cycle after a window end flushes the pipeline
    run_window(3000, 3000, 3000, 3000, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("flush_disp_mv", int'(b1.disp_mv), 0);
    chk("flush_win_code", int'(b1.win_code), 0);
    chk("flush_disp_valid", int'(b1.disp_valid), 0);
    run_window(1000, 1000, 1000, 1000, 0, 0, 1, 1, 244, 1000, 0);

    repeat (6) @(posedge clk);
    #1;
    chk("dut1_outstanding", q1.size(), 0);
    chk("dut2_outstanding", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_window_stats.md
Name: adc_window_stats

Overview:
Downstream consumer of the ADC wrapper's 16-bit sample output; sits between the ADC and the seven-segment display driver. Decimates the free-running ADC sample to a fixed sample rate and collects 2^LOG2_N samples per window. Computes average, min, max and peak-to-peak per window, scales the selected statistic to millivolts, and presents a held, saturated value suitable for the display's BCD input.

Parameters:
SAMPLE_DIV, 100000, clk cycles between sample ticks (1 kHz at 100 MHz); minimum 2
LOG2_N, 8, log2 of samples per window (256)
SCALE_NUM, 1000, millivolt numerator applied to the 12-bit code
SCALE_SHIFT, 12, right shift after multiply (1000/4096 gives 1 V full scale)
DISP_MAX, 9999, saturation ceiling for disp_mv

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_in  in  16  ADC sample, left-justified; code = s_in[15:4]
mode  in  2  0=avg, 1=min, 2=max, 3=peak-to-peak
hold  in  1  1 = freeze disp_mv and suppress disp_valid
clear  in  1  1-cycle pulse: restart current window
disp_mv  out  16  selected statistic in millivolts, binary
disp_valid  out  1  1-cycle pulse when disp_mv updates
win_code  out  12  selected statistic as raw code, registered with disp_mv

Behaviour:
- Reset: clk, rst_n only; synchronous, active-low. All counters, accumulator, disp_mv, win_code and disp_valid = 0. min tracker = 12'hFFF, max tracker = 0.
- Tick counter counts 0..SAMPLE_DIV-1. tick asserts on the cycle count == SAMPLE_DIV-1, then the counter wraps to 0.
- On tick:
  - code = s_in[15:4] is sampled.
  - acc += code; acc width 12+LOG2_N bits, never overflows.
  - min/max trackers update with code.
  - Sample counter increments.
- Window end: the tick with sample count == 2^LOG2_N-1. That tick's code is included in the statistics.
  - Stage 0 (same edge): latch avg = acc_final >> LOG2_N (truncating), min, max, and p2p = max-min, using values that include the final code.
  - Reset acc, count and trackers for the next window; next window starts fresh on the following tick.
- Stage 1 (next clk): select the statistic by mode as sampled at this cycle; compute prod = sel * SCALE_NUM, width 12+clog2(SCALE_NUM+1).
- Stage 2 (next clk):
  - mv = prod >> SCALE_SHIFT; disp_mv = min(mv, DISP_MAX).
  - win_code = sel.
  - disp_valid = 1 for exactly one cycle.
- Latency: disp_valid is high exactly 2 clk after the window-end tick cycle.
- Mode change mid-window: all four statistics are tracked in parallel, so the new mode applies to the next stage-1 cycle. No window restart.
- hold=1 at stage 2: disp_mv, win_code and disp_valid are unchanged/0. Windowing continues; the result is discarded, not queued. Releasing hold shows the next completed window.
- clear:
  - Resets tick counter, sample counter, acc and trackers.
  - Does not alter disp_mv or win_code.
  - Cancels an in-flight stage-1/2 result (no disp_valid).
  - clear and tick in the same cycle: clear wins, sample discarded.
- rst_n low mid-pipeline: pipeline flushed, outputs zero next edge, no disp_valid.
- Edge codes: a window of all 0 gives disp_mv=0 and p2p=0. A window of all 4095 gives 4095*1000>>12 = 999.

Decomposition:
- Package adc_disp_pkg:
  - mode encodings MODE_AVG=0, MODE_MIN=1, MODE_MAX=2, MODE_P2P=3
  - CODE_W=12
  - DISP_MAX_DEFAULT=9999
- Sub-module adc_win_accum: tick/sample counters, accumulator, min/max trackers. Outputs a window-done strobe plus the four statistics.
- Top adc_window_stats: stage-1 select/multiply, stage-2 scale/saturate, hold/clear gating.

Test Plan:
All tests use SAMPLE_DIV=4, LOG2_N=2.
1. s_in=16'hFFF0 constant, mode=0 -> disp_mv=999, win_code=4095; disp_valid once every 16 cycles, 2 cycles after each 4th tick.
2. Codes 100,200,300,400 on successive ticks:
   - mode=0 -> win_code 250, disp_mv 61
   - mode=1 -> 100/24
   - mode=2 -> 400/97
   - mode=3 -> 300/73
3. SCALE_NUM=40000, constant code 4095 -> raw 39990, saturated disp_mv=9999.
4. hold=1 across two window ends -> disp_valid never asserts and disp_mv keeps its old value. Release hold -> the next window shows the new value.
5. clear pulse after 2 ticks of a window (codes 4000,4000), then 4 ticks of code 0 -> disp_mv=0. Result reported 4 ticks after clear, not 2.
6. rst_n=0 for 1 cycle, 1 cycle after window end -> no disp_valid; disp_mv=0; the next window completes 16 cycles after reset release.
